cam_color_thr: RTL
==================

CAM_COLOR_THR -- requirements
Module: cam_color_thr

Interface
REQ-001 Parameter R_W, default 5: red field width, bits.
REQ-002 Parameter G_W, default 6: green field width, bits.
REQ-003 Parameter B_W, default 5: blue field width, bits.
REQ-004 Parameter NUM_WIN, default 2, range 1..4: number of independent colour windows.
REQ-005 Parameter CNT_W, default 20: per-window hit-counter width.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  pixel clock; rst_n  in  1  async active-low reset.
REQ-007 in_data  in  R_W+G_W+B_W  pixel, packed {R,G,B}, with R in the MSBs.
REQ-008 in_de, in_hs, in_vs  in  1 each  data enable, line sync and frame sync; all active-high.
REQ-009 cfg_we  in  1  single-cycle config write strobe.
REQ-010 cfg_win  in  2  target window index.
REQ-011 cfg_sel  in  3  target field: 0 rmin, 1 rmax, 2 gmin, 3 gmax, 4 bmin, 5 bmax, 6 enable (bit0).
REQ-012 cfg_data  in  8  write value; the low channel-width bits are used.
REQ-013 thr_data  out  1  1 when any enabled window matches.
REQ-014 thr_idx  out  2  lowest-index matching window; 0 when none matches.
REQ-015 thr_de, thr_hs, thr_vs  out  1 each  delayed syncs.
REQ-016 cnt_data  out  NUM_WIN*CNT_W  per-window frame hit counts; window 0 in the LSBs.
REQ-017 cnt_valid  out  1  one-cycle pulse when cnt_data updates.

Function
REQ-018 A window SHALL match when enabled and min<=ch<=max holds for R, G and B; both bounds are inclusive.
REQ-019 A window with min>max on any channel SHALL never match.
REQ-020 thr_data, thr_idx, thr_de, thr_hs and thr_vs SHALL have exactly 2-cycle latency from the inputs and be mutually aligned.
REQ-021 thr_data and thr_idx SHALL be 0 whenever thr_de is 0.
REQ-022 Config writes SHALL update a pending register set on the cycle after cfg_we.
REQ-023 The active set SHALL load from the pending set on each in_vs rising edge (in_vs=1, previous in_vs=0).
REQ-024 A write coincident with that edge SHALL reach pending only; active receives the pre-write value.
REQ-025 Writes with cfg_win>=NUM_WIN or cfg_sel=7 SHALL be ignored.
REQ-026 Each window counter SHALL increment on cycles where thr_de=1 and that window matches, independent of priority.
REQ-027 Counters SHALL saturate at 2^CNT_W-1.
REQ-028 Publish FSM states: WAIT (after reset) and RUN.
REQ-029 In WAIT, the first thr_vs rising edge SHALL clear the counters and move to RUN without asserting cnt_valid.
REQ-030 In RUN, each thr_vs rising edge SHALL copy the counters into cnt_data, pulse cnt_valid for 1 cycle and clear the counters.
REQ-031 A hit on the cycle of a thr_vs rising edge SHALL count toward the new frame.
REQ-032 thr_vs held high or hs-only activity SHALL NOT produce repeat pulses.

Reset
REQ-033 While rst_n=0, all outputs, cnt_data, counters and edge-detect flops SHALL be 0, and the FSM SHALL be in WAIT.
REQ-034 Reset SHALL set both the pending and active sets to enable=0, min=0, max=all-ones.
REQ-035 Reset asserted mid-frame SHALL discard the partial counts; no cnt_valid pulse SHALL follow until the second thr_vs rising edge after release.

Structure
REQ-036 Package cam_thr_pkg SHALL hold the cfg_sel encodings, the FSM state encoding and the thr_idx width function.
REQ-037 Sub-module cam_thr_win (pending/active registers plus compare for one window) SHALL be generated NUM_WIN times.

Verification
REQ-038 Program window 0 to R 20..31, G 40..63, B 20..31, enabled, then pulse vs; pixel {20,40,20} -> thr_data=1, idx=0 two cycles later; {19,40,20} -> 0.
REQ-039 Windows 0 and 1 both match a pixel -> thr_idx=0 and both counters +1; disable window 0 at a vs edge -> idx=1 from the next frame.
REQ-040 Write rmin=25 on the in_vs rising-edge cycle -> the current frame uses the old value; the change takes effect after the next edge.
REQ-041 Frame with 100 de pixels, 37 matching window 0 -> at the next thr_vs edge cnt_data[CNT_W-1:0]=37, cnt_valid high for 1 cycle.
REQ-042 Set CNT_W=4, 20 hits -> count 15; assert rst_n low mid-frame -> all outputs 0, first post-reset vs edge gives no cnt_valid.

Source files
------------

// File: rtl/cam_thr_pkg.sv
// Shared encodings for the colour-threshold block: config field selects,
// frame-counter FSM states and the window-index width helper.
package cam_thr_pkg;

    localparam logic [2:0] SEL_RMIN = 3'd0;
    localparam logic [2:0] SEL_RMAX = 3'd1;
    localparam logic [2:0] SEL_GMIN = 3'd2;
    localparam logic [2:0] SEL_GMAX = 3'd3;
    localparam logic [2:0] SEL_BMIN = 3'd4;
    localparam logic [2:0] SEL_BMAX = 3'd5;
    localparam logic [2:0] SEL_EN   = 3'd6;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } cnt_state_e;

    function automatic int idx_width(input int num_win);
        return (num_win > 1) ? $clog2(num_win) : 1;
    endfunction

endpackage

// File: rtl/cam_thr_win.sv
// One colour window: pending/active bound registers and the inclusive
// per-channel range compare against the stage-1 pixel.
module cam_thr_win
    import cam_thr_pkg::*;
#(
    parameter int R_W = 5,
    parameter int G_W = 6,
    parameter int B_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_we,
    input  logic [2:0]     i_sel,
    input  logic [7:0]     i_data,
    input  logic           i_load,
    input  logic [R_W-1:0] i_r,
    input  logic [G_W-1:0] i_g,
    input  logic [B_W-1:0] i_b,
    output logic           o_match
);

    logic [R_W-1:0] r_p_rmin, r_p_rmax, r_a_rmin, r_a_rmax;
    logic [G_W-1:0] r_p_gmin, r_p_gmax, r_a_gmin, r_a_gmax;
    logic [B_W-1:0] r_p_bmin, r_p_bmax, r_a_bmin, r_a_bmax;
    logic           r_p_en, r_a_en;
    logic           w_unused_data;

    assign w_unused_data = &{1'b0, i_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_rmin <= '0;
            r_p_rmax <= '1;
            r_p_gmin <= '0;
            r_p_gmax <= '1;
            r_p_bmin <= '0;
            r_p_bmax <= '1;
            r_p_en   <= 1'b0;
        end else if (i_we) begin
            case (i_sel)
                SEL_RMIN: r_p_rmin <= i_data[R_W-1:0];
                SEL_RMAX: r_p_rmax <= i_data[R_W-1:0];
                SEL_GMIN: r_p_gmin <= i_data[G_W-1:0];
                SEL_GMAX: r_p_gmax <= i_data[G_W-1:0];
                SEL_BMIN: r_p_bmin <= i_data[B_W-1:0];
                SEL_BMAX: r_p_bmax <= i_data[B_W-1:0];
                SEL_EN:   r_p_en   <= i_data[0];
                default:  ;
            endcase
        end
    end

    // The load samples pending before any coincident write lands in it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_rmin <= '0;
            r_a_rmax <= '1;
            r_a_gmin <= '0;
            r_a_gmax <= '1;
            r_a_bmin <= '0;
            r_a_bmax <= '1;
            r_a_en   <= 1'b0;
        end else if (i_load) begin
            r_a_rmin <= r_p_rmin;
            r_a_rmax <= r_p_rmax;
            r_a_gmin <= r_p_gmin;
            r_a_gmax <= r_p_gmax;
            r_a_bmin <= r_p_bmin;
            r_a_bmax <= r_p_bmax;
            r_a_en   <= r_p_en;
        end
    end

    assign o_match = r_a_en
                   && (i_r >= r_a_rmin) && (i_r <= r_a_rmax)
                   && (i_g >= r_a_gmin) && (i_g <= r_a_gmax)
                   && (i_b >= r_a_bmin) && (i_b <= r_a_bmax);

endmodule

// File: rtl/cam_color_thr.sv
// Multi-window RGB threshold with 2-cycle aligned outputs and per-frame
// hit counters published on each thr_vs rising edge.
//   state   | meaning
//   ST_WAIT | after reset; first thr_vs edge only clears the counters
//   ST_RUN  | each thr_vs edge publishes counts, pulses cnt_valid, clears
module cam_color_thr
    import cam_thr_pkg::*;
#(
    parameter int R_W     = 5,
    parameter int G_W     = 6,
    parameter int B_W     = 5,
    parameter int NUM_WIN = 2,
    parameter int CNT_W   = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [R_W+G_W+B_W-1:0]   in_data,
    input  logic                     in_de,
    input  logic                     in_hs,
    input  logic                     in_vs,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_win,
    input  logic [2:0]               cfg_sel,
    input  logic [7:0]               cfg_data,
    output logic                     thr_data,
    output logic [1:0]               thr_idx,
    output logic                     thr_de,
    output logic                     thr_hs,
    output logic                     thr_vs,
    output logic [NUM_WIN*CNT_W-1:0] cnt_data,
    output logic                     cnt_valid
);

    localparam int PIX_W = R_W + G_W + B_W;
    localparam int IDX_W = idx_width(NUM_WIN);

    logic               r_vs_prev;
    logic               w_vs_rise;
    logic [PIX_W-1:0]   r_pix;
    logic               r_de1, r_hs1, r_vs1;
    logic [NUM_WIN-1:0] w_match;
    logic [NUM_WIN-1:0] r_hit;
    logic [IDX_W-1:0]   w_idx;

    cnt_state_e         r_state, w_state_nxt;
    logic               r_tvs_prev;
    logic               w_tvs_rise;
    logic               w_clr, w_pub;
    logic [CNT_W-1:0]   r_cnt [NUM_WIN];

    assign w_vs_rise = in_vs && !r_vs_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev <= 1'b0;
            r_pix     <= '0;
            r_de1     <= 1'b0;
            r_hs1     <= 1'b0;
            r_vs1     <= 1'b0;
        end else begin
            r_vs_prev <= in_vs;
            r_pix     <= in_data;
            r_de1     <= in_de;
            r_hs1     <= in_hs;
            r_vs1     <= in_vs;
        end
    end

    for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
        cam_thr_win #(
            .R_W (R_W),
            .G_W (G_W),
            .B_W (B_W)
        ) u_win (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_we    (cfg_we && (cfg_win == 2'(g))),
            .i_sel   (cfg_sel),
            .i_data  (cfg_data),
            .i_load  (w_vs_rise),
            .i_r     (r_pix[PIX_W-1 -: R_W]),
            .i_g     (r_pix[B_W +: G_W]),
            .i_b     (r_pix[B_W-1:0]),
            .o_match (w_match[g])
        );
    end

    always_comb begin
        w_idx = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (w_match[i]) w_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_data <= 1'b0;
            thr_idx  <= 2'd0;
            thr_de   <= 1'b0;
            thr_hs   <= 1'b0;
            thr_vs   <= 1'b0;
            r_hit    <= '0;
        end else begin
            thr_data <= r_de1 && (|w_match);
            thr_idx  <= r_de1 ? 2'(w_idx) : 2'd0;
            thr_de   <= r_de1;
            thr_hs   <= r_hs1;
            thr_vs   <= r_vs1;
            r_hit    <= r_de1 ? w_match : '0;
        end
    end

    assign w_tvs_rise = thr_vs && !r_tvs_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_WAIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_pub       = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (w_tvs_rise) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_tvs_rise) begin
                    w_clr = 1'b1;
                    w_pub = 1'b1;
                end
            end
            default: w_state_nxt = ST_WAIT;
        endcase
    end

    // A hit on the edge cycle seeds the new frame's count instead of the old one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tvs_prev <= 1'b0;
            cnt_valid  <= 1'b0;
            cnt_data   <= '0;
            for (int i = 0; i < NUM_WIN; i++) r_cnt[i] <= '0;
        end else begin
            r_tvs_prev <= thr_vs;
            cnt_valid  <= w_pub;
            for (int i = 0; i < NUM_WIN; i++) begin
                if (w_pub) cnt_data[i*CNT_W +: CNT_W] <= r_cnt[i];
                if (w_clr)
                    r_cnt[i] <= CNT_W'(r_hit[i]);
                else if (r_hit[i] && (r_cnt[i] != '1))
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
        end
    end

endmodule
